// File: rtl/mips16_pkg.sv
// Shared opcode encodings and flag bit positions for the MIPS16-style execution stage.
package mips16_pkg;
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_MOV = 6'b000010;
    localparam logic [5:0] OP_AND = 6'b000100;
    localparam logic [5:0] OP_OR  = 6'b000101;
    localparam logic [5:0] OP_XOR = 6'b000110;
    localparam logic [5:0] OP_NOT = 6'b000111;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_SBI = 6'b001001;
    localparam logic [5:0] OP_MVI = 6'b001010;
    localparam logic [5:0] OP_ANI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_XRI = 6'b001110;
    localparam logic [5:0] OP_NTI = 6'b001111;
    localparam logic [5:0] OP_RET = 6'b010000;
    localparam logic [5:0] OP_HLT = 6'b010001;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_ST  = 6'b010101;
    localparam logic [5:0] OP_IN  = 6'b010110;
    localparam logic [5:0] OP_OUT = 6'b010111;
    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_LS  = 6'b011001;
    localparam logic [5:0] OP_RS  = 6'b011010;
    localparam logic [5:0] OP_RSA = 6'b011011;
    localparam logic [5:0] OP_JAL = 6'b011100;
    localparam logic [5:0] OP_BZ  = 6'b011101;
    localparam logic [5:0] OP_BNZ = 6'b011110;
    localparam logic [5:0] OP_BC  = 6'b011111;

    localparam int ZF = 1;
    localparam int CF = 0;
endpackage

// File: rtl/alu_core.sv
// Combinational result/flag computation plus per-output write enables;
// anything not enabled is held by the registers in execution_block.
module alu_core
    import mips16_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] din_i,
    input  logic [5:0]  op_i,
    output logic [15:0] ans_o,
    output logic [1:0]  flag_o,
    output logic        ans_we_o,
    output logic        flag_we_o,
    output logic        dm_we_o,
    output logic        out_we_o
);
    logic [16:0] sum;
    logic [16:0] diff;
    logic [16:0] shl;
    logic [16:0] shr;
    logic [16:0] sra;
    logic [3:0]  n;
    logic        carry;

    assign n    = b_i[3:0];
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    // Right shifts carry a guard bit below the LSB so bit 0 is the last bit shifted out.
    assign shl  = {1'b0, a_i} << n;
    assign shr  = {a_i, 1'b0} >> n;
    assign sra  = $signed({a_i, 1'b0}) >>> n;

    always_comb begin
        ans_o     = a_i;
        carry     = 1'b0;
        ans_we_o  = 1'b1;
        flag_we_o = 1'b0;
        dm_we_o   = 1'b0;
        out_we_o  = 1'b0;
        case (op_i)
            OP_ADD, OP_ADI: begin ans_o = sum[15:0];  carry = sum[16];  flag_we_o = 1'b1; end
            OP_SUB, OP_SBI: begin ans_o = diff[15:0]; carry = diff[16]; flag_we_o = 1'b1; end
            OP_MOV, OP_MVI: begin ans_o = b_i;        flag_we_o = 1'b1; end
            OP_AND, OP_ANI: begin ans_o = a_i & b_i;  flag_we_o = 1'b1; end
            OP_OR,  OP_ORI: begin ans_o = a_i | b_i;  flag_we_o = 1'b1; end
            OP_XOR, OP_XRI: begin ans_o = a_i ^ b_i;  flag_we_o = 1'b1; end
            OP_NOT, OP_NTI: begin ans_o = ~b_i;       flag_we_o = 1'b1; end
            OP_LS:  begin ans_o = shl[15:0]; carry = shl[16]; flag_we_o = 1'b1; end
            OP_RS:  begin ans_o = shr[16:1]; carry = shr[0];  flag_we_o = 1'b1; end
            OP_RSA: begin ans_o = sra[16:1]; carry = sra[0];  flag_we_o = 1'b1; end
            OP_LD:  ans_o = a_i;
            OP_ST:  dm_we_o = 1'b1;
            OP_IN:  ans_o = din_i;
            OP_OUT: out_we_o = 1'b1;
            OP_RET, OP_JMP, OP_JAL, OP_BZ, OP_BNZ, OP_BC: ans_o = a_i;
            default: ans_we_o = 1'b0;
        endcase
        flag_o        = 2'b00;
        flag_o[ZF]    = (ans_o == 16'h0000);
        flag_o[CF]    = carry;
    end
endmodule

// File: rtl/execution_block.sv
// Execution stage: registers the ALU result, flags, store data and output port
// with one cycle of latency; synchronous active-low reset clears everything.
module execution_block
    import mips16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] data_in,
    input  logic [5:0]  op_dec,
    output logic [15:0] ans_ex,
    output logic [15:0] DM_data,
    output logic [15:0] data_out,
    output logic [1:0]  flag_ex
);
    logic [15:0] ans_d;
    logic [1:0]  flag_d;
    logic        ans_we, flag_we, dm_we, out_we;
    logic [15:0] ans_q, dm_q, out_q;
    logic [1:0]  flag_q;

    alu_core u_alu (
        .a_i       (A),
        .b_i       (B),
        .din_i     (data_in),
        .op_i      (op_dec),
        .ans_o     (ans_d),
        .flag_o    (flag_d),
        .ans_we_o  (ans_we),
        .flag_we_o (flag_we),
        .dm_we_o   (dm_we),
        .out_we_o  (out_we)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ans_q  <= 16'h0000;
            dm_q   <= 16'h0000;
            out_q  <= 16'h0000;
            flag_q <= 2'b00;
        end else begin
            if (ans_we)  ans_q  <= ans_d;
            if (flag_we) flag_q <= flag_d;
            if (dm_we)   dm_q   <= B;
            if (out_we)  out_q  <= A;
        end
    end

    assign ans_ex   = ans_q;
    assign DM_data  = dm_q;
    assign data_out = out_q;
    assign flag_ex  = flag_q;
endmodule

// File: tb/tb_execution_block.sv
// Directed bench for execution_block: the driver queues hand-computed
// {ans_ex, DM_data, data_out, flag_ex} tuples; a monitor pops one per edge.
module tb_execution_block;
    logic        clk;
    logic        reset;
    logic [15:0] A, B, data_in;
    logic [5:0]  op_dec;
    logic [15:0] ans_ex, DM_data, data_out;
    logic [1:0]  flag_ex;

    logic [49:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    execution_block dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .data_in  (data_in),
        .op_dec   (op_dec),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .data_out (data_out),
        .flag_ex  (flag_ex)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: apply inputs on the falling edge, queue the state expected after the next rising edge
    task automatic step(input string nm, input logic rst, input logic [5:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] din,
                        input logic [15:0] e_ans, input logic [15:0] e_dm,
                        input logic [15:0] e_out, input logic [1:0] e_flag);
        @(negedge clk);
        reset   = rst;
        op_dec  = op;
        A       = a;
        B       = b;
        data_in = din;
        exp_q.push_back({e_ans, e_dm, e_out, e_flag});
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    initial begin
        logic [49:0] exp_v;
        logic [49:0] act_v;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {ans_ex, DM_data, data_out, flag_ex};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL %s: got ans=%h dm=%h out=%h flag=%b, want ans=%h dm=%h out=%h flag=%b",
                             nm, act_v[49:34], act_v[33:18], act_v[17:2], act_v[1:0],
                             exp_v[49:34], exp_v[33:18], exp_v[17:2], exp_v[1:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; A = 16'h0; B = 16'h0; data_in = 16'h0; op_dec = 6'b000000;
        //    name          rst  op         A         B         din       ans       dm        out       flag
        step("reset",       0, 6'b000000, 16'h4000, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00);
        step("add",         1, 6'b000000, 16'h4000, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b11);
        step("sub",         1, 6'b000001, 16'h4000, 16'hC000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 2'b01);
        step("and",         1, 6'b000100, 16'h4000, 16'hC000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 2'b00);
        step("or",          1, 6'b000101, 16'h4000, 16'hC000, 16'h0000, 16'hC000, 16'h0000, 16'h0000, 2'b00);
        step("xor",         1, 6'b000110, 16'h4000, 16'hC000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 2'b00);
        step("not",         1, 6'b000111, 16'h4000, 16'hC000, 16'h0000, 16'h3FFF, 16'h0000, 16'h0000, 2'b00);
        step("ls",          1, 6'b011001, 16'h8001, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 2'b01);
        step("rs",          1, 6'b011010, 16'h8001, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 2'b01);
        step("rsa",         1, 6'b011011, 16'h8001, 16'h0001, 16'h0000, 16'hC000, 16'h0000, 16'h0000, 2'b01);
        step("ls_zero",     1, 6'b011001, 16'h8001, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 2'b00);
        step("rs_by4",      1, 6'b011010, 16'h00F8, 16'h0004, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 2'b01);
        step("in",          1, 6'b010110, 16'h1111, 16'h2222, 16'h0008, 16'h0008, 16'h0000, 16'h0000, 2'b01);
        step("st",          1, 6'b010101, 16'h4000, 16'hC000, 16'h0000, 16'h4000, 16'hC000, 16'h0000, 2'b01);
        step("out",         1, 6'b010111, 16'h4000, 16'hC000, 16'h0000, 16'h4000, 16'hC000, 16'h4000, 2'b01);
        step("add_hold",    1, 6'b000000, 16'h4000, 16'hC000, 16'h0000, 16'h0000, 16'hC000, 16'h4000, 2'b11);
        step("jmp",         1, 6'b011000, 16'h1234, 16'h0001, 16'h0000, 16'h1234, 16'hC000, 16'h4000, 2'b11);
        step("hlt",         1, 6'b010001, 16'h5555, 16'h0001, 16'h0000, 16'h1234, 16'hC000, 16'h4000, 2'b11);
        step("undef",       1, 6'b000011, 16'h7777, 16'h0000, 16'h0000, 16'h1234, 16'hC000, 16'h4000, 2'b11);
        step("undef_13",    1, 6'b010011, 16'h7777, 16'h0000, 16'h0000, 16'h1234, 16'hC000, 16'h4000, 2'b11);
        step("ld",          1, 6'b010100, 16'h00AA, 16'h0000, 16'h0000, 16'h00AA, 16'hC000, 16'h4000, 2'b11);
        step("mvi_zero",    1, 6'b001010, 16'h00AA, 16'h0000, 16'h0000, 16'h0000, 16'hC000, 16'h4000, 2'b10);
        step("adi_wrap",    1, 6'b001000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hC000, 16'h4000, 2'b11);
        step("mid_reset",   0, 6'b000001, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00);
        step("sub_after",   1, 6'b000001, 16'h0005, 16'h0003, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 2'b00);
        step("sbi_borrow",  1, 6'b001001, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 2'b01);
        step("ori",         1, 6'b001101, 16'h0F00, 16'h00F0, 16'h0000, 16'h0FF0, 16'h0000, 16'h0000, 2'b00);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
